// File: rtl/logic_arb_pkg.sv
// Shared opcode encodings and FSM state type for the logic unit arbiter.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    OpAnd = 2'b00,
    OpOr  = 2'b01,
    OpXor = 2'b10,
    OpNor = 2'b11
  } op_e;

  typedef enum logic {
    StIdle,
    StResp
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Two-requester operation bus plus result channel of the logic unit arbiter.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 32
);

  logic             req0_valid;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_ready;

  // Requesters and result consumer side.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );

endinterface

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: AND, OR, XOR, NOR.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpNor:   y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Time-shares one logic unit between two requesters with an IDLE/RESP FSM.
// Define LOGIC_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 wins.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             gnt_any;
  logic             gnt;
  logic             accept;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;
  op_e              op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] lu_y;

  assign gnt_any = bus.req0_valid | bus.req1_valid;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On contention favour whoever was not served last.
  assign gnt = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt;
    end
  end
`else
  assign gnt = bus.req1_valid & ~bus.req0_valid;
`endif

  assign accept = (state_q == StIdle) & gnt_any;

  assign op_sel = gnt ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
  assign a_sel  = gnt ? bus.req1_a : bus.req0_a;
  assign b_sel  = gnt ? bus.req1_b : bus.req0_b;

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .op(op_sel),
    .a (a_sel),
    .b (b_sel),
    .y (lu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Readies are gated by rst so they stay low for the whole reset window.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if ((state_q == StIdle) && !rst && gnt_any) begin
      bus.req0_ready = ~gnt;
      bus.req1_ready = gnt;
    end
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_id    = rsp_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else if (accept) begin
      rsp_data_q <= lu_y;
      rsp_id_q   <= gnt;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus multi-cycle sequences.
module tb_logic_unit_arbiter;

  logic clk;
  logic rst;

  logic_unit_arbiter_if #(.WIDTH(32)) bus ();

  logic_unit_arbiter #(
    .WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        v0;
    logic        v1;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        r0;
    logic        r1;
    logic        rsp;
    logic [31:0] data;
    logic        id;
  } vec_t;

  vec_t vecs[6];
  logic exp_order[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"and0", 1, 0, 2'b00, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'h0,
                1, 0, 1, 32'h0F0F0000, 0};
    vecs[1] = '{"or0", 1, 0, 2'b01, 2'b00, 32'h12340000, 32'h00005678, 32'h0, 32'h0,
                1, 0, 1, 32'h12345678, 0};
    vecs[2] = '{"nor1", 0, 1, 2'b00, 2'b11, 32'h0, 32'h0, 32'h00000000, 32'h00000001,
                0, 1, 1, 32'hFFFFFFFE, 1};
    vecs[3] = '{"xor0", 1, 0, 2'b10, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0,
                1, 0, 1, 32'h0FF00FF0, 0};
    vecs[4] = '{"and1", 0, 1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h12345678, 32'h0000FFFF,
                0, 1, 1, 32'h00005678, 1};
    vecs[5] = '{"none", 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
                0, 0, 0, 32'h0, 0};
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready  = 1;

    // Reset state, with a pending request that must not be granted.
    rst = 1;
    bus.req0_valid = 1;
    #12;
    check("rst_ready0", 32'(bus.req0_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    bus.req0_valid = 0;
    @(negedge clk);
    rst = 0;
    step();

    // Single-request vectors, one accept/consume round trip each.
    for (int i = 0; i < 6; i++) begin
      bus.req0_valid = vecs[i].v0; bus.req0_op = vecs[i].op0;
      bus.req0_a = vecs[i].a0;     bus.req0_b = vecs[i].b0;
      bus.req1_valid = vecs[i].v1; bus.req1_op = vecs[i].op1;
      bus.req1_a = vecs[i].a1;     bus.req1_b = vecs[i].b1;
      #1;
      check({vecs[i].name, "_ready0"}, 32'(bus.req0_ready), 32'(vecs[i].r0));
      check({vecs[i].name, "_ready1"}, 32'(bus.req1_ready), 32'(vecs[i].r1));
      check({vecs[i].name, "_pre_valid"}, 32'(bus.rsp_valid), 0);
      step();
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      check({vecs[i].name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(vecs[i].rsp));
      if (vecs[i].rsp) begin
        check({vecs[i].name, "_rsp_data"}, bus.rsp_data, vecs[i].data);
        check({vecs[i].name, "_rsp_id"}, 32'(bus.rsp_id), 32'(vecs[i].id));
      end
      step();
      check({vecs[i].name, "_idle_valid"}, 32'(bus.rsp_valid), 0);
    end

    // Backpressure: result held while req0 waits with readies low.
    bus.rsp_ready = 0;
    bus.req1_valid = 1; bus.req1_op = 2'b10;
    bus.req1_a = 32'hAAAAAAAA; bus.req1_b = 32'hFFFFFFFF;
    step();
    bus.req1_valid = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b00;
    bus.req0_a = 32'hFFFFFFFF; bus.req0_b = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_data", bus.rsp_data, 32'h55555555);
      check("bp_rsp_id", 32'(bus.rsp_id), 1);
      check("bp_ready0", 32'(bus.req0_ready), 0);
      check("bp_ready1", 32'(bus.req1_ready), 0);
      step();
    end
    bus.rsp_ready = 1;
    #1;
    check("bp_consume_ready0", 32'(bus.req0_ready), 0);
    step();
    check("bp_idle_valid", 32'(bus.rsp_valid), 0);
    check("bp_idle_ready0", 32'(bus.req0_ready), 1);
    bus.req0_valid = 0;
    step();
    check("bp_no_accept", 32'(bus.rsp_valid), 0);

    // Operand change after acceptance must not alter the held result.
    bus.rsp_ready = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b00;
    bus.req0_a = 32'hFFFF0000; bus.req0_b = 32'h0F0F0F0F;
    step();
    bus.req0_a = 32'h00000000;
    bus.req0_b = 32'hFFFFFFFF;
    step();
    check("opchg_rsp_data", bus.rsp_data, 32'h0F0F0000);
    check("opchg_rsp_valid", 32'(bus.rsp_valid), 1);

    // Asynchronous reset while a result is pending.
    #2;
    rst = 1;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("arst_rsp_data", bus.rsp_data, 0);
    check("arst_ready0", 32'(bus.req0_ready), 0);

    // Contention after reset release, consumer always ready.
    bus.req0_valid = 1; bus.req0_op = 2'b01;
    bus.req0_a = 32'h000000F0; bus.req0_b = 32'h0000000F;
    bus.req1_valid = 1; bus.req1_op = 2'b11;
    bus.req1_a = 32'h00000000; bus.req1_b = 32'h00000000;
    bus.rsp_ready = 1;
    @(negedge clk);
    rst = 0;
    for (int g = 0; g < 4; g++) begin
      #1;
      check($sformatf("cont%0d_ready0", g), 32'(bus.req0_ready), 32'(!exp_order[g]));
      check($sformatf("cont%0d_ready1", g), 32'(bus.req1_ready), 32'(exp_order[g]));
      step();
      check($sformatf("cont%0d_rsp_id", g), 32'(bus.rsp_id), 32'(exp_order[g]));
      check($sformatf("cont%0d_rsp_data", g), bus.rsp_data,
            exp_order[g] ? 32'hFFFFFFFF : 32'h000000FF);
      check($sformatf("cont%0d_resp_ready0", g), 32'(bus.req0_ready), 0);
      @(posedge clk);
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
